// File: rtl/qpsk_symbol_mapper.sv
// QPSK symbol mapper: turns a packetised byte stream into Gray-mapped sc16 IQ samples,
// SPS samples per symbol, four symbols per byte (bits [7:6] first).
// Output item: {I[15:0], Q[15:0]}, two's complement.
// Optional feature macro: QPSK_DIFF_ENC_EN (differential phase encoding across symbols).
module qpsk_symbol_mapper #(
    parameter int unsigned SPS        = 4,
    parameter int          AMP        = 11585,
    parameter int unsigned ZERO_STUFF = 0
) (
    input  logic        ce_clk,
    input  logic        ce_rst_n,
    input  logic        enable,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        busy
);

    typedef enum logic {StIdle, StEmit} state_e;

    localparam logic [15:0] AmpPos   = 16'(AMP);
    localparam logic [15:0] AmpNeg   = 16'(-AMP);
    localparam logic [3:0]  SampLast = 4'(SPS - 1);

    state_e      state_q, state_d;
    logic [7:0]  byte_q;
    logic        last_q;
    logic [1:0]  sym_q;
    logic [3:0]  samp_q;

    logic        s_hs, m_hs;
    logic        samp_wrap, final_samp;
    logic [1:0]  sign_sel;   // {I negative, Q negative}

    function automatic logic [1:0] dibit_of(input logic [7:0] b, input logic [1:0] idx);
        logic [1:0] d;
        unique case (idx)
            2'd0: d = b[7:6];
            2'd1: d = b[5:4];
            2'd2: d = b[3:2];
            2'd3: d = b[1:0];
        endcase
        return d;
    endfunction

    assign samp_wrap  = (samp_q == SampLast);
    assign final_samp = (sym_q == 2'd3) && samp_wrap;
    assign s_hs       = s_axis_tvalid && s_axis_tready;
    assign m_hs       = m_axis_tvalid && m_axis_tready;

    // State register
    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) state_q <= StIdle;
        else           state_q <= state_d;
    end

    // Next-state: a byte accepted on the final sample keeps us in EMIT with no bubble
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (s_hs) state_d = StEmit;
            StEmit: if (m_hs && final_samp && !s_hs) state_d = StIdle;
        endcase
    end

    // Outputs: all driven from registers; only s_axis_tready looks at m_axis_tready
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 32'h0;
        m_axis_tlast  = 1'b0;
        busy          = 1'b0;
        unique case (state_q)
            StIdle: s_axis_tready = enable;
            StEmit: begin
                s_axis_tready = enable && final_samp && m_axis_tready;
                m_axis_tvalid = 1'b1;
                busy          = 1'b1;
                m_axis_tlast  = last_q && final_samp;
                if (!((ZERO_STUFF != 0) && (samp_q != 4'd0))) begin
                    m_axis_tdata = {sign_sel[1] ? AmpNeg : AmpPos,
                                    sign_sel[0] ? AmpNeg : AmpPos};
                end
            end
        endcase
    end

    // Byte/tlast capture and symbol/sample counters; counters hold under backpressure
    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            byte_q <= 8'h0;
            last_q <= 1'b0;
            sym_q  <= 2'd0;
            samp_q <= 4'd0;
        end else if (s_hs) begin
            byte_q <= s_axis_tdata;
            last_q <= s_axis_tlast;
            sym_q  <= 2'd0;
            samp_q <= 4'd0;
        end else if (m_hs) begin
            if (samp_wrap) begin
                samp_q <= 4'd0;
                sym_q  <= sym_q + 2'd1;
            end else begin
                samp_q <= samp_q + 4'd1;
            end
        end
    end

`ifdef QPSK_DIFF_ENC_EN
    // phase_q holds the accumulated phase of the symbol currently being emitted
    logic [1:0] phase_q, phase_d, phase_base;

    function automatic logic [1:0] phase_inc(input logic [1:0] d);
        logic [1:0] inc;
        unique case (d)
            2'b00: inc = 2'd0;
            2'b01: inc = 2'd1;
            2'b11: inc = 2'd2;
            2'b10: inc = 2'd3;
        endcase
        return inc;
    endfunction

    // A new byte starts from zero phase if the previous byte closed a packet
    assign phase_base = ((state_q == StEmit) && last_q) ? 2'd0 : phase_q;

    // Phase next-state: advance once per symbol, clear at the end of a tlast byte
    always_comb begin
        phase_d = phase_q;
        if (s_hs) begin
            phase_d = phase_base + phase_inc(s_axis_tdata[7:6]);
        end else if (m_hs && samp_wrap) begin
            if (final_samp) phase_d = last_q ? 2'd0 : phase_q;
            else            phase_d = phase_q + phase_inc(dibit_of(byte_q, sym_q + 2'd1));
        end
    end

    // Phase register
    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) phase_q <= 2'd0;
        else           phase_q <= phase_d;
    end

    // Phase to quadrant signs: 0 (+,+), 1 (-,+), 2 (-,-), 3 (+,-)
    always_comb begin
        unique case (phase_q)
            2'd0: sign_sel = 2'b00;
            2'd1: sign_sel = 2'b10;
            2'd2: sign_sel = 2'b11;
            2'd3: sign_sel = 2'b01;
        endcase
    end
`else
    // Direct Gray mapping: dibit bit 1 sets I sign, bit 0 sets Q sign
    always_comb begin
        sign_sel = dibit_of(byte_q, sym_q);
    end
`endif

endmodule
